// File: rtl/fanout_fork_reg.sv
// fanout_fork_reg: registered eager-fork stage.
// Holds one word taken from a ready/valid producer and offers it to every
// active branch (branch_en & branch_sel). Each branch takes the word at most
// once per entry. The entry frees when every active branch has either taken
// it already or is taking it this cycle.
//
// Ports
//   clk, rst_n   clock, asynchronous active-low reset
//   flush        synchronous clear of the entry and the per-branch done bits
//   in_data      upstream payload
//   in_valid     upstream valid
//   in_ready     upstream ready (combinational from out_ready)
//   branch_en    per-branch enable
//   branch_sel   per-branch route select
//   out_data     held payload, shared by all branches
//   out_valid    per-branch valid
//   out_ready    per-branch ready

// Per-branch slice: done bit, offer and "not blocking release" term.
module fanout_fork_lane (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,    // new entry, drain or flush: forget completion
  input  logic full,
  input  logic en,
  input  logic sel,
  input  logic rdy,
  output logic valid,
  output logic pass    // this branch does not hold the entry back
);
  logic done;
  logic active;

  assign active = en & sel;
  assign valid  = full & active & ~done;
  // Inactive branches never block; a branch that has already taken the
  // word or is taking it now is also out of the way.
  assign pass   = ~active | done | rdy;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)          done <= 1'b0;
    else if (clr)        done <= 1'b0;
    else if (valid & rdy) done <= 1'b1;
  end
endmodule

module fanout_fork_reg #(
  parameter int NUM_BRANCH = 7,
  parameter int DATA_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  flush,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [NUM_BRANCH-1:0] branch_en,
  input  logic [NUM_BRANCH-1:0] branch_sel,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic [NUM_BRANCH-1:0] out_valid,
  input  logic [NUM_BRANCH-1:0] out_ready
);
  logic                  full;
  logic [DATA_WIDTH-1:0] data_q;
  logic [NUM_BRANCH-1:0] pass;
  logic                  drain;
  logic                  accept;
  logic                  clr;

  assign drain    = full & (&pass);
  // Drain and refill in the same cycle keeps one word per cycle flowing.
  assign in_ready = ~full | drain;
  assign accept   = in_valid & in_ready;
  assign clr      = flush | accept | drain;
  assign out_data = data_q;

  for (genvar i = 0; i < NUM_BRANCH; i++) begin : g_lane
    fanout_fork_lane u_lane (
      .clk   (clk),
      .rst_n (rst_n),
      .clr   (clr),
      .full  (full),
      .en    (branch_en[i]),
      .sel   (branch_sel[i]),
      .rdy   (out_ready[i]),
      .valid (out_valid[i]),
      .pass  (pass[i])
    );
  end

  // Flush wins over a simultaneous accept: the upstream sees a transfer
  // but the word is dropped and data_q keeps its old value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      full   <= 1'b0;
      data_q <= '0;
    end else if (flush) begin
      full   <= 1'b0;
    end else if (accept) begin
      full   <= 1'b1;
      data_q <= in_data;
    end else if (drain) begin
      full   <= 1'b0;
    end
  end
endmodule

// File: doc/fanout_fork_reg.md
Name: fanout_fork_reg

Overview:
- Registered eager-fork stage that drives the fanout ready-merge logic.
- Captures one word from a ready/valid producer and presents it to up to NUM_BRANCH consumers.
- Tracks per-branch completion, so a branch that has already accepted the word is not offered it again.
- Frees the entry once every active branch has taken the word. The combined upstream ready is the same enable/select/ready AND the fanout merge produces.

Parameters:
- NUM_BRANCH, 7, number of fanout destinations.
- DATA_WIDTH, 16, payload width.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- flush  input  1  synchronous clear of entry and done bits.
- in_data  input  DATA_WIDTH  upstream payload.
- in_valid  input  1  upstream valid.
- in_ready  output  1  upstream ready.
- branch_en  input  NUM_BRANCH  per-branch enable (config).
- branch_sel  input  NUM_BRANCH  per-branch route-select bit (config).
- out_data  output  DATA_WIDTH  held payload, common to all branches.
- out_valid  output  NUM_BRANCH  per-branch valid.
- out_ready  input  NUM_BRANCH  per-branch ready.

Behaviour:
- Interface: one clock; reset is asynchronous and active-low. Ports are clk and rst_n.
- State:
  - full: 1 bit.
  - data_q: DATA_WIDTH.
  - done: NUM_BRANCH.
- Reset: full=0, data_q=0, done=0. Hence out_valid=0, out_data=0, in_ready=1.
- active[i] = branch_en[i] & branch_sel[i].
- out_valid[i] = full & active[i] & ~done[i]. out_data = data_q.
- fire[i] = out_valid[i] & out_ready[i].
- release = full & AND over i of (~active[i] | done[i] | out_ready[i]). This is combinational within the same cycle.
- in_ready = ~full | release. This is a combinational path from out_ready, giving throughput of 1 word/cycle.
- accept = in_valid & in_ready.
- Next state, priority order:
  1. flush: full=0 and done=0. data_q is unchanged. Any accept in the same cycle is dropped. in_ready must still follow the formula above; the upstream will consider the word transferred.
  2. accept: data_q=in_data, full=1, done=0. This applies whether or not release is asserted, so back-to-back transfers are supported.
  3. release without accept: full=0, done=0.
  4. Otherwise, for each i: done[i] |= fire[i].
- Latency: a word accepted at edge t is presented on out_valid/out_data from cycle t+1.
- Zero active branches while full: release=1 immediately. The word is discarded in one cycle with no out_valid asserted.
- Config changes while full are permitted. active is re-evaluated every cycle. A branch deactivated mid-entry no longer blocks release. A branch activated mid-entry with done[i]=0 is offered the word.
- A branch with done[i]=1 never sees out_valid[i] again for the same entry.
- out_ready[i] with out_valid[i]=0 has no effect on done.
- in_valid may drop without transfer. Stability of the upstream payload is the upstream's responsibility.
- Reset asserted mid-entry: the entry is lost immediately. There are no pending handshakes after deassertion.
- Done bits are sized NUM_BRANCH. No arithmetic; no wrap behaviour.

Test Plan:
- Reset/idle:
  - Stimulus: hold rst_n=0 then release, with in_valid=0.
  - Required: out_valid=0, out_data=0, in_ready=1.
- Full fanout, single cycle:
  - Stimulus: en=sel=7'h7F, out_ready=7'h7F, stream 0x0001..0x0008 back-to-back.
  - Required: each word appears on out_data one cycle after accept, with out_valid=7'h7F. in_ready stays 1. 8 words complete in 9 cycles.
- Staggered readies:
  - Stimulus: en=sel=7'h07, word 0xBEEF. out_ready=001 in cycle 1, 010 in cycle 2, 100 in cycle 3.
  - Required:
    - out_valid sequence 111 → 110 → 100.
    - in_ready=0 in cycles 1–2 and 1 in cycle 3.
    - Branch 0 never re-sees 0xBEEF.
- Masking:
  - Stimulus: en=7'h7F, sel=7'h05, out_ready=7'h05, word 0x1234.
  - Required: out_valid=7'h05 only. Released in 1 cycle even though out_ready[1]=0.
- No active branch:
  - Stimulus: en=0, word 0xAAAA.
  - Required: out_valid stays 0. Entry drains the next cycle; a second word is accepted in the cycle after the first accept.
- Flush and mid-entry reset:
  - Stimulus, part 1: entry held with done=7'h01; assert flush together with in_valid carrying 0x5555.
  - Required, part 1: next cycle full=0, out_valid=0, and 0x5555 is not presented.
  - Stimulus, part 2: repeat with a rst_n pulse instead of flush.
  - Required, part 2: out_valid=0 asynchronously.
